// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared definitions for the bit-serial arithmetic units
// (serial_sub4 today, a serial adder later).
//   state_e   : controller state encoding (IDLE / SHIFT / DONE)
//   cnt_width : bit-counter width for a given operand width
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int unsigned DEF_WIDTH = 4;

   // Counter must hold 0..w-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

   localparam int unsigned DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/serial_sub4_full_sub1.sv
// full_sub1: combinational 1-bit full subtractor, d = x - y - bi.
//   x  : minuend bit
//   y  : subtrahend bit
//   bi : borrow in
//   d  : difference bit
//   bo : borrow out
module full_sub1 (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub4.sv
// serial_sub4: bit-serial two's-complement subtractor, diff = a - b - b_in,
// one bit per clock, LSB first, using a single full_sub1 cell and a borrow flop.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow output.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   start : request, sampled only in IDLE
//   a, b  : minuend / subtrahend, captured on accepted start
//   b_in  : borrow-in, captured on accepted start
//   busy  : high while an operation is in SHIFT or DONE
//   done  : one-cycle pulse, diff/b_out valid
//   diff  : a - b - b_in mod 2^WIDTH, held until the next result
//   b_out : final borrow (unsigned underflow)
//   ovf   : signed overflow (only with SERIAL_SUB_OVF_EN)
module serial_sub4
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] d_sr_q, d_sr_d;
   logic [WIDTH-1:0] diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             b_out_d;
   logic             busy_d, done_d;
   logic             last_c;
   logic             fs_d, fs_bo;
`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             ovf_d;
`endif

   // Single subtractor cell operating on the current LSBs.
   full_sub1 u_full_sub1 (
      .x  (a_sr_q[0]),
      .y  (b_sr_q[0]),
      .bi (br_q),
      .d  (fs_d),
      .bo (fs_bo)
   );

   assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)  state_d = SHIFT;
         SHIFT:   if (last_c) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      d_sr_d  = d_sr_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff;
      b_out_d = b_out;
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
`ifdef SERIAL_SUB_OVF_EN
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      ovf_d   = ovf;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sr_d = a;
               b_sr_d = b;
               br_d   = b_in;
               cnt_d  = '0;
               d_sr_d = '0;
`ifdef SERIAL_SUB_OVF_EN
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1];
`endif
            end
         end
         SHIFT: begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            br_d   = fs_bo;
            // New bit enters at the MSB so the result ends up in order.
            d_sr_d = {fs_d, d_sr_q[WIDTH-1:1]};
            cnt_d  = CNT_W'(cnt_q + 1'b1);
            if (last_c) begin
               diff_d  = {fs_d, d_sr_q[WIDTH-1:1]};
               b_out_d = fs_bo;
`ifdef SERIAL_SUB_OVF_EN
               // fs_d is the result MSB on the final shift.
               ovf_d = (a_msb_q ^ b_msb_q) & (fs_d ^ a_msb_q);
`endif
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         d_sr_q  <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff    <= '0;
         b_out   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf     <= 1'b0;
`endif
      end else begin
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         d_sr_q  <= d_sr_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff    <= diff_d;
         b_out   <= b_out_d;
         busy    <= busy_d;
         done    <= done_d;
`ifdef SERIAL_SUB_OVF_EN
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf     <= ovf_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_sub4.sv
// tb_serial_sub4: self-checking bench for serial_sub4 with an arithmetic
// reference model (plain integer subtraction and signed range check).
module tb_serial_sub4;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         b_in;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   serial_sub4 #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .b_in  (b_in),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   // One full operation: start presented now, done expected in cycle 5.
   // With ign set, start is pulsed with other operands during SHIFT and
   // during the done cycle; both must be ignored.
   task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic obin, input string tag, input bit ign);
      int           r;
      logic [W-1:0] e_diff;
      logic         e_bout;
      logic         e_busy, e_done;
`ifdef SERIAL_SUB_OVF_EN
      int           sa, sb, sr;
      logic         e_ovf;
      sa = oa[W-1] ? int'(oa) - (1 << W) : int'(oa);
      sb = ob[W-1] ? int'(ob) - (1 << W) : int'(ob);
      sr = sa - sb - int'(obin);
      e_ovf = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
`endif
      r      = int'(oa) - int'(ob) - int'(obin);
      e_diff = r[W-1:0];
      e_bout = (r < 0);
      start = 1'b1; a = oa; b = ob; b_in = obin;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         @(posedge clk); #1;
         start = ign && (cyc == 2 || cyc == 5);
         if (start) begin
            a = W'(10); b = W'(15); b_in = 1'b0;
         end else begin
            a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
         end
         e_busy = (cyc <= 5);
         e_done = (cyc == 5);
         n_cmp++;
         if (busy !== e_busy) begin
            n_fail++;
            $display("FAIL %s busy cyc%0d: got %b want %b", tag, cyc, busy, e_busy);
         end
         n_cmp++;
         if (done !== e_done) begin
            n_fail++;
            $display("FAIL %s done cyc%0d: got %b want %b", tag, cyc, done, e_done);
         end
         if (cyc == 5) begin
            n_cmp++;
            if (diff !== e_diff) begin
               n_fail++;
               $display("FAIL %s diff: got %h want %h", tag, diff, e_diff);
            end
            n_cmp++;
            if (b_out !== e_bout) begin
               n_fail++;
               $display("FAIL %s b_out: got %b want %b", tag, b_out, e_bout);
            end
`ifdef SERIAL_SUB_OVF_EN
            n_cmp++;
            if (ovf !== e_ovf) begin
               n_fail++;
               $display("FAIL %s ovf: got %b want %b", tag, ovf, e_ovf);
            end
`endif
         end
         if (cyc == 6) begin
            n_cmp++;
            if (diff !== e_diff) begin
               n_fail++;
               $display("FAIL %s diff hold: got %h want %h", tag, diff, e_diff);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, diff, b_out} !== '0) begin
         n_fail++;
         $display("FAIL reset: got busy=%b done=%b diff=%h b_out=%b want all 0",
                  busy, done, diff, b_out);
      end
`ifdef SERIAL_SUB_OVF_EN
      n_cmp++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset ovf: got %b want 0", ovf);
      end
`endif
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         a = W'($urandom); b = W'($urandom);
         n_cmp++;
         if ({busy, done, diff, b_out} !== '0) begin
            n_fail++;
            $display("FAIL idle cyc%0d: got busy=%b done=%b diff=%h b_out=%b want all 0",
                     i, busy, done, diff, b_out);
         end
      end
   endtask

   task automatic test_basic_borrow();
      do_op(W'(3), W'(4), 1'b0, "borrow_3m4", 1'b0);
   endtask

   task automatic test_back_to_back();
      do_op(W'(9),  W'(9), 1'b0, "b2b_9m9",    1'b0);
      do_op(W'(10), W'(5), 1'b1, "b2b_10m5m1", 1'b0);
   endtask

   task automatic test_wrap_ignore();
      do_op(W'(0),  W'(0),  1'b1, "wrap_0m0m1", 1'b1);
      do_op(W'(10), W'(15), 1'b0, "wrap_10m15", 1'b0);
   endtask

   task automatic test_reset_mid();
      start = 1'b1; a = W'(7); b = W'(2); b_in = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_cmp++;
      if ({busy, done, diff, b_out} !== '0) begin
         n_fail++;
         $display("FAIL midreset: got busy=%b done=%b diff=%h b_out=%b want all 0",
                  busy, done, diff, b_out);
      end
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset quiet cyc%0d: got busy=%b done=%b want 0 0",
                     i, busy, done);
         end
      end
      do_op(W'(7), W'(2), 1'b0, "after_reset_7m2", 1'b0);
   endtask

`ifdef SERIAL_SUB_OVF_EN
   task automatic test_ovf();
      do_op(W'(7), W'(8), 1'b0, "ovf_7m8", 1'b0);
      do_op(W'(8), W'(1), 1'b0, "ovf_8m1", 1'b0);
      do_op(W'(5), W'(2), 1'b0, "ovf_5m2", 1'b0);
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 25; i++)
         do_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", i), 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic_borrow();
      test_back_to_back();
      test_wrap_ignore();
      test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
      test_ovf();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
